// File: rtl/bf16_norm_round_if.sv
// Handshake and data bundle for the bf16 normalise/round stage.
// Signal names follow the stage's original port names; the slave modport is
// the stage's view, the master modport is the producer/consumer view.
interface bf16_norm_round_if #(
    parameter int E = 8,
    parameter int M = 7
);
    logic           in_valid_i;
    logic           in_ready_o;
    logic           s_i;
    logic [E-1:0]   e_i;
    logic [M+3:0]   m_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic           s_o;
    logic [E-1:0]   e_o;
    logic [M-1:0]   m_o;
    logic           of_o;
    logic           uf_o;
    logic           nx_o;

    modport slave (
        input  in_valid_i, s_i, e_i, m_i, out_ready_i,
        output in_ready_o, out_valid_o, s_o, e_o, m_o, of_o, uf_o, nx_o
    );

    modport master (
        output in_valid_i, s_i, e_i, m_i, out_ready_i,
        input  in_ready_o, out_valid_o, s_o, e_o, m_o, of_o, uf_o, nx_o
    );
endinterface

// File: rtl/bf16_norm_round.sv
// Two-stage normalise and round-to-nearest-even stage for a floating-point
// adder. Stage 1 captures the raw sum and its leading-zero count; stage 2
// normalises, rounds and packs the result with overflow/underflow/inexact
// flags. Valid/ready handshake on both sides.
module bf16_norm_round #(
    parameter int E = 8,
    parameter int M = 7
) (
    input  logic              clk,
    input  logic              rst,
    bf16_norm_round_if.slave  bus
);

    localparam int LZW = $clog2(M + 4);
    localparam int XW  = E + 2;
    localparam logic signed [XW-1:0] EMAX = XW'((1 << E) - 1);

    // Stage 1 registers
    logic               r1_valid;
    logic               r1_s;
    logic [E-1:0]       r1_e;
    logic [M+3:0]       r1_m;
    logic [LZW-1:0]     r1_lzc;

    // Stage 2 registers (drive the outputs directly)
    logic               r2_valid;
    logic               r2_s;
    logic [E-1:0]       r2_e;
    logic [M-1:0]       r2_m;
    logic               r2_of;
    logic               r2_uf;
    logic               r2_nx;

    // Handshake
    logic               w_in_ready;
    logic               w_s1_accept;
    logic               w_s2_load;

    // Leading-zero scan
    logic [LZW-1:0]     w_lzc;
    logic [M+2:0]       w_scan;
    logic               w_found;

    // Normalise/round datapath
    logic [M+2:0]           w_norm;     // {hidden, fraction, guard, sticky}
    logic signed [XW-1:0]   w_exp_n;
    logic signed [XW-1:0]   w_exp_r;
    logic [M:0]             w_frac_r;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_inc;
    logic [E-1:0]           w_e;
    logic [M-1:0]           w_m;
    logic                   w_of;
    logic                   w_uf;
    logic                   w_nx;
    logic                   w_unused;

    assign w_in_ready  = ~r1_valid | ~r2_valid | bus.out_ready_i;
    assign w_s1_accept = bus.in_valid_i & w_in_ready;
    assign w_s2_load   = r1_valid & (~r2_valid | bus.out_ready_i);

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = r2_valid;
    assign bus.s_o         = r2_s;
    assign bus.e_o         = r2_e;
    assign bus.m_o         = r2_m;
    assign bus.of_o        = r2_of;
    assign bus.uf_o        = r2_uf;
    assign bus.nx_o        = r2_nx;

    // Leading-zero count of m_i[M+2:0], counted down from the hidden-bit position
    always_comb begin
        w_scan  = bus.m_i[M+2:0];
        w_lzc   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < M + 3; i++) begin
            if (!w_found) begin
                if (w_scan[M+2]) begin
                    w_found = 1'b1;
                end else begin
                    w_scan = w_scan << 1;
                    w_lzc  = w_lzc + LZW'(1);
                end
            end
        end
    end

    // Stage 1: capture the raw sum and its leading-zero count
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_s     <= 1'b0;
            r1_e     <= '0;
            r1_m     <= '0;
            r1_lzc   <= '0;
        end else begin
            r1_valid <= w_s1_accept | (r1_valid & ~w_s2_load);
            if (w_s1_accept) begin
                r1_s   <= bus.s_i;
                r1_e   <= bus.e_i;
                r1_m   <= bus.m_i;
                r1_lzc <= w_lzc;
            end
        end
    end

    // Normalise, round to nearest even, then classify zero/underflow/overflow
    always_comb begin
        if (r1_m[M+3]) begin
            // Carry out: shift right one, old guard folds into sticky
            w_norm  = {r1_m[M+3:2], r1_m[1] | r1_m[0]};
            w_exp_n = {2'b00, r1_e} + XW'(1);
        end else begin
            w_norm  = r1_m[M+2:0] << r1_lzc;
            w_exp_n = {2'b00, r1_e} - XW'(r1_lzc);
        end
        w_guard  = w_norm[1];
        w_sticky = w_norm[0];
        w_inc    = w_guard & (w_sticky | w_norm[2]);
        w_frac_r = {1'b0, w_norm[M+1:2]} + (M+1)'(w_inc);
        w_exp_r  = w_exp_n + XW'(w_frac_r[M]);

        w_e  = '0;
        w_m  = '0;
        w_of = 1'b0;
        w_uf = 1'b0;
        w_nx = 1'b0;
        if (r1_m == '0) begin
            w_nx = 1'b0;
        end else if (w_exp_n <= 0) begin
            w_uf = 1'b1;
            w_nx = 1'b1;
        end else if (w_exp_r >= EMAX) begin
            w_e  = '1;
            w_of = 1'b1;
            w_nx = 1'b1;
        end else begin
            w_e  = w_exp_r[E-1:0];
            w_m  = w_frac_r[M-1:0];
            w_nx = w_guard | w_sticky;
        end
    end

    // The hidden bit is implied by normalisation and never stored
    assign w_unused = w_norm[M+2];

    // Stage 2: register the packed result; holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_s     <= 1'b0;
            r2_e     <= '0;
            r2_m     <= '0;
            r2_of    <= 1'b0;
            r2_uf    <= 1'b0;
            r2_nx    <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r2_valid <= 1'b1;
                r2_s     <= r1_s;
                r2_e     <= w_e;
                r2_m     <= w_m;
                r2_of    <= w_of;
                r2_uf    <= w_uf;
                r2_nx    <= w_nx;
            end else if (bus.out_ready_i) begin
                r2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bf16_norm_round.sv
// Self-checking bench for bf16_norm_round: directed vector table, stall and
// reset sequences, and randomized traffic against a value-level reference.
module tb_bf16_norm_round;

    localparam int E = 8;
    localparam int M = 7;

    typedef logic [18:0] res_t;   // {s, e[7:0], m[6:0], of, uf, nx}

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [10:0] m;
        res_t        exp_r;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    res_t q_exp[$];
    res_t held;
    bit   held_v = 1'b0;
    vec_t tbl[14];

    always #5 clk = ~clk;

    bf16_norm_round_if #(.E(E), .M(M)) bus ();

    bf16_norm_round #(.E(E), .M(M)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic res_t dut_res();
        return {bus.s_o, bus.e_o, bus.m_o, bus.of_o, bus.uf_o, bus.nx_o};
    endfunction

    // Reference: treat m as an integer significand with the hidden bit at
    // weight 2^(M+2), find its MSB, keep M+1 bits and round the remainder RNE.
    function automatic res_t ref_model(input logic s, input logic [7:0] e, input logic [10:0] m);
        int mi, p, en, sh, kept, rem, half;
        logic nx;
        logic [7:0] eo;
        logic [6:0] fo;
        mi = int'(m);
        if (mi == 0) return {s, 8'd0, 7'd0, 3'b000};
        p = 10;
        while (((mi >> p) & 1) == 0) p--;
        en = int'(e) + p - (M + 2);
        if (p > M) begin
            sh   = p - M;
            kept = mi >> sh;
            rem  = mi & ((1 << sh) - 1);
            half = 1 << (sh - 1);
        end else begin
            kept = mi << (M - p);
            rem  = 0;
            half = 0;
        end
        nx = (rem != 0);
        if (en <= 0) return {s, 8'd0, 7'd0, 3'b011};
        if (rem > half || (rem == half && rem != 0 && (kept % 2) == 1)) kept++;
        if (kept == (1 << (M + 1))) begin
            kept = kept / 2;
            en++;
        end
        if (en >= 255) return {s, 8'hff, 7'd0, 3'b101};
        eo = 8'(en);
        fo = 7'(kept - 128);
        return {s, eo, fo, 1'b0, 1'b0, nx};
    endfunction

    // Scoreboard and hold-stability monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            q_exp.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", 32'(bus.out_valid_o), 32'd1);
                chk("hold_stable", 32'(dut_res()), 32'(held));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (q_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got %0h expected no output", dut_res());
                end else begin
                    chk("scoreboard", 32'(dut_res()), 32'(q_exp.pop_front()));
                end
            end
            held_v = bus.out_valid_o && !bus.out_ready_i;
            held   = dut_res();
            if (bus.in_valid_i && bus.in_ready_o)
                q_exp.push_back(ref_model(bus.s_i, bus.e_i, bus.m_i));
        end
    end

    task automatic drive(input logic s, input logic [7:0] e, input logic [10:0] m);
        bus.s_i        = s;
        bus.e_i        = e;
        bus.m_i        = m;
        bus.in_valid_i = 1'b1;
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [10:0] m);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        drive(s, e, m);
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = bus.in_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid_i = 1'b0;
        chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!bus.out_valid_o && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic rand_vec(output logic s, output logic [7:0] e, output logic [10:0] m);
        int mode, k;
        logic [10:0] t;
        mode = $urandom_range(0, 5);
        s    = 1'($urandom);
        t    = 11'($urandom);
        case (mode)
            0:       m = '0;
            3:       m = t >> $urandom_range(1, 10);
            4:       m = {2'b01, t[8:0]};
            5:       m = t | 11'h400;
            default: m = t;
        endcase
        if (m == '0) begin
            e = 8'($urandom);
        end else begin
            k = $urandom_range(0, 9);
            case (k)
                0:       e = 8'd1;
                1:       e = 8'd2;
                2:       e = 8'd254;
                3:       e = 8'd253;
                default: e = 8'($urandom_range(1, 254));
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rs;
        logic [7:0]  re;
        logic [10:0] rm;
        int          idx;
        bit          acc;
        bit          seen;
        int          n;

        tbl[0]  = '{1'b0, 8'd127, 11'b10_0000000_00, {1'b0, 8'd128, 7'd0,        3'b000}};
        tbl[1]  = '{1'b0, 8'd130, 11'b00_0000001_00, {1'b0, 8'd123, 7'd0,        3'b000}};
        tbl[2]  = '{1'b0, 8'd127, 11'b01_0000001_10, {1'b0, 8'd127, 7'b0000010,  3'b001}};
        tbl[3]  = '{1'b0, 8'd127, 11'b01_0000000_10, {1'b0, 8'd127, 7'd0,        3'b001}};
        tbl[4]  = '{1'b0, 8'd127, 11'b01_1111111_11, {1'b0, 8'd128, 7'd0,        3'b001}};
        tbl[5]  = '{1'b0, 8'd254, 11'b10_0000000_00, {1'b0, 8'd255, 7'd0,        3'b101}};
        tbl[6]  = '{1'b1, 8'd3,   11'b00_0000100_00, {1'b1, 8'd0,   7'd0,        3'b011}};
        tbl[7]  = '{1'b1, 8'd77,  11'b00_0000000_00, {1'b1, 8'd0,   7'd0,        3'b000}};
        tbl[8]  = '{1'b1, 8'd100, 11'b01_1010101_00, {1'b1, 8'd100, 7'b1010101,  3'b000}};
        tbl[9]  = '{1'b0, 8'd1,   11'b01_0000000_00, {1'b0, 8'd1,   7'd0,        3'b000}};
        tbl[10] = '{1'b0, 8'd1,   11'b00_1000000_00, {1'b0, 8'd0,   7'd0,        3'b011}};
        tbl[11] = '{1'b0, 8'd254, 11'b01_1111111_11, {1'b0, 8'd255, 7'd0,        3'b101}};
        tbl[12] = '{1'b0, 8'd10,  11'b11_0000001_11, {1'b0, 8'd11,  7'b1000001,  3'b001}};
        tbl[13] = '{1'b0, 8'd50,  11'b00_1111111_11, {1'b0, 8'd50,  7'd0,        3'b001}};

        // Reset with in_valid high: the offered word must be ignored
        rst             = 1'b1;
        bus.out_ready_i = 1'b1;
        drive(1'b0, 8'd100, 11'b01_0101010_00);
        repeat (3) @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_result", 32'(dut_res()), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.out_valid_o) seen = 1'b1;
        end
        chk("rst_input_ignored", 32'(seen), 32'd0);

        // Two-cycle latency from accept to out_valid
        drive(tbl[0].s, tbl[0].e, tbl[0].m);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        chk("latency_edge1", 32'(bus.out_valid_o), 32'd0);
        @(posedge clk);
        #1;
        chk("latency_edge2", 32'(bus.out_valid_o), 32'd1);
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            send(tbl[i].s, tbl[i].e, tbl[i].m);
            wait_out();
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid_o), 32'd1);
            chk($sformatf("vec%0d", i), 32'(dut_res()), 32'(tbl[i].exp_r));
            @(posedge clk);
            #1;
        end

        // Stall: three words offered over four blocked cycles, two get in
        bus.out_ready_i = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(tbl[idx + 2].s, tbl[idx + 2].e, tbl[idx + 2].m);
            @(negedge clk);
            acc = bus.in_ready_o;
            @(posedge clk);
            #1;
            if (acc && idx < 2) idx++;
        end
        chk("stall_accepted", 32'(idx), 32'd2);
        chk("stall_in_ready", 32'(bus.in_ready_o), 32'd0);
        chk("stall_out_valid", 32'(bus.out_valid_o), 32'd1);
        bus.out_ready_i = 1'b1;
        send(tbl[4].s, tbl[4].e, tbl[4].m);
        n = 0;
        while ((q_exp.size() != 0 || bus.out_valid_o) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_drain", 32'(q_exp.size()), 32'd0);

        // Reset while stalled drops in-flight words
        bus.out_ready_i = 1'b0;
        send(tbl[8].s, tbl[8].e, tbl[8].m);
        send(tbl[9].s, tbl[9].e, tbl[9].m);
        @(posedge clk);
        #1;
        chk("rstmid_full", 32'(bus.out_valid_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rstmid_in_ready", 32'(bus.in_ready_o), 32'd1);
        rst             = 1'b0;
        bus.out_ready_i = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.out_valid_o) seen = 1'b1;
        end
        chk("rstmid_no_output", 32'(seen), 32'd0);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 600; c++) begin
            if (($urandom % 4) != 0) begin
                rand_vec(rs, re, rm);
                drive(rs, re, rm);
            end else begin
                bus.in_valid_i = 1'b0;
            end
            bus.out_ready_i = (($urandom % 10) < 7);
            @(posedge clk);
            #1;
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        n = 0;
        while ((q_exp.size() != 0 || bus.out_valid_o) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rand_drain", 32'(q_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bf16_norm_round.md
BF16_NORM_ROUND -- requirements
Module: bf16_norm_round

Interface
REQ-001 SHALL have parameters: E, default 8, exponent width; M, default 7, stored fraction width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid_i  in  1  raw sum valid.
- in_ready_o  out  1  stage can accept.
- s_i  in  1  raw sign.
- e_i  in  E  raw exponent (exponent of larger operand).
- m_i  in  M+4  raw significand {carry, hidden, fraction[M-1:0], guard, sticky}.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts.
- s_o  out  1  result sign.
- e_o  out  E  result exponent.
- m_o  out  M  result fraction.
- of_o  out  1  exponent overflow, result forced to infinity.
- uf_o  out  1  underflow, result flushed to zero.
- nx_o  out  1  inexact: nonzero guard/sticky before rounding.
REQ-003 SHALL accept input contract e_i in 1..2^E-2, or m_i==0 with any e_i; other inputs are don't-care.

Function
REQ-004 SHALL be a 2-stage valid/ready pipeline: S1 registers input and leading-zero count; S2 registers the shifted, rounded, packed result.
REQ-005 SHALL transfer on in_valid_i & in_ready_o and on out_valid_o & out_ready_i; latency 2 cycles from accept to out_valid_o with no stall.
REQ-006 SHALL drive in_ready_o = ~s1_valid | ~s2_valid | out_ready_i; full throughput of 1 result per cycle when out_ready_i is high.
REQ-007 SHALL hold all outputs stable while out_valid_o & ~out_ready_i, and SHALL preserve order with no loss or duplication.
REQ-008 SHALL normalise on carry set: shift right 1, exponent+1, shifted-out guard ORed into sticky.
REQ-009 SHALL normalise on carry clear: shift left by lzc, the leading-zero count of m_i[M+2:0] measured from the hidden position; exponent-lzc.
REQ-010 SHALL compute exponent arithmetic in E+2-bit signed width.
REQ-011 SHALL round to nearest even: increment fraction when G & (S | LSB); carry out of fraction gives fraction 0, exponent+1.
REQ-012 SHALL output exact zero {s_i,0,0} when m_i==0; nx_o=0, uf_o=0.
REQ-013 SHALL flush when the normalised exponent is <=0: e_o=0, m_o=0, sign kept, uf_o=1, nx_o=1; subnormals are not produced.
REQ-014 SHALL force infinity when the final exponent is >=2^E-1, including overflow caused by rounding: e_o=all ones, m_o=0, of_o=1, nx_o=1.
REQ-015 SHALL keep flags aligned with their result and valid only when out_valid_o=1.

Reset
REQ-016 SHALL clear s1_valid and s2_valid on rst, giving out_valid_o=0 and in_ready_o=1 the cycle after reset.
REQ-017 SHALL drive s_o, e_o, m_o, of_o, uf_o and nx_o to 0 in reset.
REQ-018 SHALL discard in-flight results when rst is asserted mid-stream; no output appears for them afterwards.
REQ-019 SHALL ignore in_valid_i during rst.

Verification
REQ-020 SHALL cover: carry case s=0, e=127, m_i=11'b10_0000000_00 -> {s,e,m}=16'h4000, flags 0.
REQ-021 SHALL cover: cancellation e=130, m_i=11'b00_0000001_00 -> e_o=123, m_o=0, nx_o=0.
REQ-022 SHALL cover: ties e=127, m_i=11'b01_0000001_10 -> m_o=7'b0000010, nx_o=1; and m_i=11'b01_0000000_10 -> m_o=0, nx_o=1.
REQ-023 SHALL cover: rounding carry e=127, m_i=11'b01_1111111_11 -> e_o=128, m_o=0; and e=254 with carry set -> e_o=255, m_o=0, of_o=1.
REQ-024 SHALL cover: underflow e=3, m_i=11'b00_0000100_00 (lzc=5) -> e_o=0, m_o=0, uf_o=1.
REQ-025 SHALL cover: out_ready_i=0 for 4 cycles while 3 inputs are offered -> 2 held, in_ready_o=0, release gives in-order outputs; rst mid-stall -> out_valid_o=0 the next cycle.
